// File: rtl/deadtime_gate_driver.sv
// Per-phase dead-time insertion and shoot-through protection between the commutation stage and the gate pins.
// Optional minimum on-time is enabled by defining DT_MIN_ON_EN.
module deadtime_gate_driver #(
    parameter int DEAD_CYCLES   = 8,
    parameter int MIN_ON_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fault_clr,
    input  logic [5:0] mosfet_in,
    output logic [5:0] gate_out,
    output logic       fault,
    output logic [2:0] fault_phase,
    output logic [2:0] dead_active
);

    localparam int DW = $clog2(DEAD_CYCLES + 1);

    // Misconfigured dead time would allow zero-gap handover.
    if (DEAD_CYCLES < 1 || MIN_ON_CYCLES < 1) begin : g_param_check
        $error("deadtime_gate_driver: DEAD_CYCLES and MIN_ON_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, HI, LO, DEAD} phase_t;

    phase_t        state [3];
    logic [DW-1:0] dcnt  [3];

    logic [2:0] req_h;
    logic [2:0] req_l;
    logic [2:0] illegal;
    logic [2:0] leave_hi;
    logic [2:0] leave_lo;
    logic [2:0] min_done;
    logic       any_illegal;
    logic       block;

    assign req_h       = mosfet_in[5:3];
    assign req_l       = mosfet_in[2:0];
    assign illegal     = req_h & req_l;
    assign any_illegal = |illegal;
    assign block       = fault | any_illegal;
    assign leave_hi    = ~req_h | req_l;
    assign leave_lo    = ~req_l | req_h;

`ifdef DT_MIN_ON_EN
    localparam int MW = $clog2(MIN_ON_CYCLES + 1);

    logic [MW-1:0] mcnt [3];

    always_comb begin
        min_done = '0;
        for (int p = 0; p < 3; p++) begin
            min_done[p] = (mcnt[p] == '0);
        end
    end
`else
    assign min_done = 3'b111;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_out    <= '0;
            fault       <= 1'b0;
            fault_phase <= '0;
            dead_active <= 3'b111;
            for (int p = 0; p < 3; p++) begin
                state[p] <= DEAD;
                dcnt[p]  <= DW'(DEAD_CYCLES);
`ifdef DT_MIN_ON_EN
                mcnt[p]  <= '0;
`endif
            end
        end else begin
            // Phase capture only on a fresh latch or a rejected clear attempt.
            if (any_illegal) begin
                fault <= 1'b1;
                if (!fault || fault_clr) begin
                    fault_phase <= illegal;
                end
            end else if (fault_clr) begin
                fault       <= 1'b0;
                fault_phase <= '0;
            end

            for (int p = 0; p < 3; p++) begin
                case (state[p])
                    IDLE: begin
                        if (!block && en) begin
                            if (req_h[p] && !req_l[p]) begin
                                state[p]      <= HI;
                                gate_out[p+3] <= 1'b1;
`ifdef DT_MIN_ON_EN
                                mcnt[p]       <= MW'(MIN_ON_CYCLES - 1);
`endif
                            end else if (req_l[p] && !req_h[p]) begin
                                state[p]    <= LO;
                                gate_out[p] <= 1'b1;
`ifdef DT_MIN_ON_EN
                                mcnt[p]     <= MW'(MIN_ON_CYCLES - 1);
`endif
                            end
                        end
                    end
                    HI: begin
                        if (block || !en || (leave_hi[p] && min_done[p])) begin
                            state[p]       <= DEAD;
                            gate_out[p+3]  <= 1'b0;
                            dead_active[p] <= 1'b1;
                            dcnt[p]        <= DW'(DEAD_CYCLES);
                        end
`ifdef DT_MIN_ON_EN
                        else if (mcnt[p] != '0) begin
                            mcnt[p] <= mcnt[p] - MW'(1);
                        end
`endif
                    end
                    LO: begin
                        if (block || !en || (leave_lo[p] && min_done[p])) begin
                            state[p]       <= DEAD;
                            gate_out[p]    <= 1'b0;
                            dead_active[p] <= 1'b1;
                            dcnt[p]        <= DW'(DEAD_CYCLES);
                        end
`ifdef DT_MIN_ON_EN
                        else if (mcnt[p] != '0) begin
                            mcnt[p] <= mcnt[p] - MW'(1);
                        end
`endif
                    end
                    DEAD: begin
                        if (dcnt[p] <= DW'(1)) begin
                            state[p]       <= IDLE;
                            dead_active[p] <= 1'b0;
                        end else begin
                            dcnt[p] <= dcnt[p] - DW'(1);
                        end
                    end
                    default: begin
                        state[p]       <= DEAD;
                        gate_out[p+3]  <= 1'b0;
                        gate_out[p]    <= 1'b0;
                        dead_active[p] <= 1'b1;
                        dcnt[p]        <= DW'(DEAD_CYCLES);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deadtime_gate_driver.sv
// Directed bench for deadtime_gate_driver with DEAD_CYCLES=8, MIN_ON_CYCLES=4.
// Min-on expectations follow DT_MIN_ON_EN when the bench is built with it.
module tb_deadtime_gate_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fault_clr;
    logic [5:0] mosfet_in;
    logic [5:0] gate_out;
    logic       fault;
    logic [2:0] fault_phase;
    logic [2:0] dead_active;

    int checks = 0;
    int errors = 0;

    deadtime_gate_driver #(.DEAD_CYCLES(8), .MIN_ON_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fault_clr   (fault_clr),
        .mosfet_in   (mosfet_in),
        .gate_out    (gate_out),
        .fault       (fault),
        .fault_phase (fault_phase),
        .dead_active (dead_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        fault_clr = 1'b0;
        mosfet_in = 6'b000_000;
        #12;
        chk("rst_gate", 8'(gate_out), 8'h00);
        chk("rst_fault", 8'(fault), 8'h00);
        chk("rst_fphase", 8'(fault_phase), 8'h00);
        chk("rst_dead", 8'(dead_active), 8'h07);

        // Startup: UH appears on the 9th edge after release.
        rst       = 1'b0;
        en        = 1'b1;
        mosfet_in = 6'b100_000;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("startup_gate", 8'(gate_out), (i == 9) ? 8'h20 : 8'h00);
            chk("startup_dead", 8'(dead_active), (i < 8) ? 8'h07 : 8'h00);
        end

        // Handover UH -> UL.
        mosfet_in = 6'b000_100;
        tick();
        chk("hand_fall", 8'(gate_out), 8'h00);
        chk("hand_dead", 8'(dead_active), 8'h04);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("hand_gap", 8'(gate_out), (i == 9) ? 8'h04 : 8'h00);
            chk("hand_dead_cnt", 8'(dead_active), (i < 8) ? 8'h04 : 8'h00);
        end

        // Independence: VL held while UH is chopped.
        mosfet_in = 6'b000_010;
        tick();
        chk("indep_v_on", 8'(gate_out), 8'h02);
        repeat (8) begin
            tick();
            chk("indep_settle", 8'(gate_out), 8'h02);
        end
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 23; k++) begin
                mosfet_in = (k < 3) ? 6'b100_010 : 6'b000_010;
                tick();
                chk("indep_chop", 8'(gate_out), (k < 3) ? 8'h22 : 8'h02);
            end
        end

        // Fault on U; V drops out through dead time.
        mosfet_in = 6'b100_100;
        tick();
        chk("flt_set", 8'(fault), 8'h01);
        chk("flt_phase", 8'(fault_phase), 8'h04);
        chk("flt_gate", 8'(gate_out), 8'h00);
        chk("flt_dead", 8'(dead_active), 8'h02);
        mosfet_in = 6'b000_000;
        tick();
        chk("flt_persist", 8'(fault), 8'h01);
        chk("flt_persist_ph", 8'(fault_phase), 8'h04);
        mosfet_in = 6'b100_100;
        fault_clr = 1'b1;
        tick();
        chk("flt_clr_ignored", 8'(fault), 8'h01);
        chk("flt_clr_ign_gate", 8'(gate_out), 8'h00);
        mosfet_in = 6'b100_000;
        tick();
        fault_clr = 1'b0;
        chk("flt_cleared", 8'(fault), 8'h00);
        chk("flt_cleared_ph", 8'(fault_phase), 8'h00);
        chk("flt_clr_gate", 8'(gate_out), 8'h00);
        tick();
        chk("flt_resume", 8'(gate_out), 8'h20);

        // Fault on V while U is HI: U must wait out full dead time after clear.
        mosfet_in = 6'b110_010;
        tick();
        chk("flt2_set", 8'(fault), 8'h01);
        chk("flt2_phase", 8'(fault_phase), 8'h02);
        chk("flt2_gate", 8'(gate_out), 8'h00);
        chk("flt2_dead", 8'(dead_active), 8'h06);
        mosfet_in = 6'b100_000;
        fault_clr = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            fault_clr = 1'b0;
            chk("flt2_wait", 8'(gate_out), (i == 9) ? 8'h20 : 8'h00);
        end
        chk("flt2_clear", 8'(fault), 8'h00);

        // New fault on the same edge as a clear.
        mosfet_in = 6'b001_001;
        tick();
        chk("flt3_phase_w", 8'(fault_phase), 8'h01);
        mosfet_in = 6'b010_010;
        fault_clr = 1'b1;
        tick();
        chk("flt3_stays", 8'(fault), 8'h01);
        chk("flt3_phase_v", 8'(fault_phase), 8'h02);
        mosfet_in = 6'b000_000;
        tick();
        fault_clr = 1'b0;
        chk("flt3_clear", 8'(fault), 8'h00);
        chk("flt3_clear_ph", 8'(fault_phase), 8'h00);

        // Disable for two cycles.
        mosfet_in = 6'b100_000;
        repeat (10) tick();
        chk("dis_pre", 8'(gate_out), 8'h20);
        en = 1'b0;
        tick();
        chk("dis_fall", 8'(gate_out), 8'h00);
        chk("dis_dead", 8'(dead_active), 8'h04);
        tick();
        chk("dis_hold", 8'(gate_out), 8'h00);
        en = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            tick();
            chk("dis_resume", 8'(gate_out), (i == 9) ? 8'h20 : 8'h00);
        end

        // Asynchronous reset mid-HI, away from any clock edge.
        #3;
        rst = 1'b1;
        #1;
        chk("arst_gate", 8'(gate_out), 8'h00);
        chk("arst_dead", 8'(dead_active), 8'h07);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("arst_restart", 8'(gate_out), (i == 9) ? 8'h20 : 8'h00);
        end

        // Single-cycle UH request.
        mosfet_in = 6'b000_000;
        repeat (10) tick();
        mosfet_in = 6'b100_000;
        tick();
        chk("short_on", 8'(gate_out), 8'h20);
        mosfet_in = 6'b000_000;
        for (int i = 1; i <= 4; i++) begin
            tick();
`ifdef DT_MIN_ON_EN
            chk("short_width", 8'(gate_out), (i < 4) ? 8'h20 : 8'h00);
`else
            chk("short_width", 8'(gate_out), 8'h00);
`endif
        end

        // Same request, en dropped at cycle 2.
        repeat (10) tick();
        mosfet_in = 6'b100_000;
        tick();
        chk("short_en_on", 8'(gate_out), 8'h20);
        mosfet_in = 6'b000_000;
        tick();
`ifdef DT_MIN_ON_EN
        chk("short_en_c1", 8'(gate_out), 8'h20);
`else
        chk("short_en_c1", 8'(gate_out), 8'h00);
`endif
        en = 1'b0;
        tick();
        chk("short_en_off", 8'(gate_out), 8'h00);
        en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
